// File: rtl/program_loader.sv
// Boot-time program loader: collects a little-endian byte stream into 32-bit
// instruction words, writes each one into instruction memory, then pulses the CPU start.
module program_loader #(
    parameter int WORD_W    = 32,
    parameter int MAX_WORDS = 128,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic [CNT_W-1:0]             prog_len,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         load,
    output logic [WORD_W-1:0]            ins,
    output logic [$clog2(MAX_WORDS)-1:0] ins_adr,
    output logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int ADR_W = $clog2(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, START, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  word_cnt;
    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] asm_word;

    // Status flags are pure decodes of the state register, so they change
    // on the same edge as the state itself.
    assign byte_ready = (state == COLLECT);
    assign busy       = (state == COLLECT) || (state == WRITE) || (state == START);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
            load     <= 1'b0;
            start    <= 1'b0;
            ins      <= '0;
            ins_adr  <= '0;
            err      <= 1'b0;
        end else begin
            load  <= 1'b0;
            start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        if (prog_len == '0 || prog_len > CNT_W'(MAX_WORDS)) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            err      <= 1'b0;
                            len      <= prog_len;
                            word_cnt <= '0;
                            byte_cnt <= '0;
                            state    <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        asm_word[{byte_cnt, 3'b000} +: 8] <= byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Last byte goes straight into ins so load rises with WRITE.
                        if (byte_cnt == 2'd3) begin
                            load    <= 1'b1;
                            ins     <= {byte_data, asm_word[WORD_W-9:0]};
                            ins_adr <= word_cnt[ADR_W-1:0];
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    byte_cnt <= '0;
                    if (word_cnt + CNT_W'(1) == len) begin
                        start <= 1'b1;
                        state <= START;
                    end else begin
                        state <= COLLECT;
                    end
                end
                START:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a monitor records every load/start/byte
// transfer, and each task compares them against words built from the byte list.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic [7:0] prog_len = '0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = '0;
    logic       byte_ready, load, start, busy, done, err;
    logic [31:0] ins;
    logic [6:0]  ins_adr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit noise = 0;

    int          ld_adr[$];
    logic [31:0] ld_word[$];
    int          ld_cyc[$];
    int          st_cyc[$];
    int          xf_cyc[$];
    int          ready_bad = 0;

    program_loader dut (
        .clk(clk), .rst(rst), .go(go), .prog_len(prog_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .load(load), .ins(ins), .ins_adr(ins_adr), .start(start),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (load) begin
            ld_adr.push_back(int'(ins_adr));
            ld_word.push_back(ins);
            ld_cyc.push_back(cyc);
            if (byte_ready) ready_bad++;
        end
        if (start) st_cyc.push_back(cyc);
        if (byte_valid && byte_ready) xf_cyc.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ld_adr.delete(); ld_word.delete(); ld_cyc.delete();
        st_cyc.delete(); xf_cyc.delete(); ready_bad = 0;
    endtask

    task automatic start_load(input int n);
        go = 1'b1;
        prog_len = 8'(n);
        step();
        go = 1'b0;
        prog_len = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        logic r;
        byte_valid = 1'b1;
        byte_data  = b;
        do begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            #1;
            n++;
            if (noise) begin
                go = 1'($urandom);
                prog_len = 8'($urandom);
            end
        end while (!r && n < 200);
        if (!r) begin
            checks++; errors++;
            $display("FAIL byte_accept timeout: byte_ready stayed 0, required 1");
        end
        byte_valid = 1'b0;
    endtask

    // Full load: model expects word i = little-endian bytes 4i..4i+3 at address i.
    task automatic run_prog(input string name, input int n, input logic [7:0] bytes[$],
                            input int gmin, input int gmax);
        int k;
        logic [31:0] exp_w;
        clear_mon();
        start_load(n);
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i == bytes.size() - 1) begin
                go = 1'b0;
                prog_len = '0;
            end else begin
                repeat ($urandom_range(gmax, gmin)) step();
            end
        end
        k = 0;
        while (!done && k < 50) begin step(); k++; end
        step();
        checks++;
        if (ld_word.size() !== n) begin
            errors++;
            $display("FAIL %s load_count: got %0d required %0d", name, ld_word.size(), n);
        end
        for (int i = 0; i < n && i < ld_word.size(); i++) begin
            exp_w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            checks++;
            if (ld_word[i] !== exp_w || ld_adr[i] !== i) begin
                errors++;
                $display("FAIL %s word[%0d]: got %h@%0d required %h@%0d",
                         name, i, ld_word[i], ld_adr[i], exp_w, i);
            end
            if (xf_cyc.size() >= 4*i+4) begin
                checks++;
                if (ld_cyc[i] !== xf_cyc[4*i+3] + 1) begin
                    errors++;
                    $display("FAIL %s load_latency[%0d]: got cycle %0d required %0d",
                             name, i, ld_cyc[i], xf_cyc[4*i+3] + 1);
                end
            end
        end
        checks++;
        if (xf_cyc.size() !== 4*n) begin
            errors++;
            $display("FAIL %s xfer_count: got %0d required %0d", name, xf_cyc.size(), 4*n);
        end
        checks++;
        if (st_cyc.size() !== 1 || ld_cyc.size() == 0 || st_cyc[0] !== ld_cyc[ld_cyc.size()-1] + 1) begin
            errors++;
            $display("FAIL %s start_pulse: got %0d pulses, required exactly 1 right after last load",
                     name, st_cyc.size());
        end
        checks++;
        if (ready_bad !== 0) begin
            errors++;
            $display("FAIL %s ready_in_write: got %0d cycles with byte_ready=1 during load, required 0",
                     name, ready_bad);
        end
        checks++;
        if ({done, busy, err, load, start} !== 5'b10000) begin
            errors++;
            $display("FAIL %s final_status: got done/busy/err/load/start=%b required 10000",
                     name, {done, busy, err, load, start});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({byte_ready, load, start, busy, done, err, ins, ins_adr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {byte_ready, load, start, busy, done, err, ins, ins_adr});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] b[$] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        run_prog("basic", 2, b, 0, 0);
    endtask

    task automatic test_stall();
        logic [7:0] b[$] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        run_prog("stall", 2, b, 3, 3);
    endtask

    task automatic test_err();
        logic [7:0] b[$];
        clear_mon();
        start_load(0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_len0: got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        start_load(129);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_len129: got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        repeat (5) step();
        checks++;
        if (ld_word.size() !== 0 || st_cyc.size() !== 0) begin
            errors++;
            $display("FAIL err_no_activity: got %0d loads %0d starts required 0 0",
                     ld_word.size(), st_cyc.size());
        end
        repeat (4) b.push_back(8'($urandom));
        run_prog("err_recover", 1, b, 0, 2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_mon();
        start_load(1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        step();
        checks++;
        if ({byte_ready, load, start, busy, done, err, ins, ins_adr} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required all zero",
                     {byte_ready, load, start, busy, done, err, ins, ins_adr});
        end
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (ld_word.size() !== 0 || st_cyc.size() !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d loads %0d starts required 0 0",
                     ld_word.size(), st_cyc.size());
        end
        run_prog("deadbeef", 1, b, 0, 1);
    endtask

    task automatic test_go_ignored();
        logic [7:0] b[$];
        repeat (12) b.push_back(8'($urandom));
        noise = 1;
        run_prog("go_ignored", 3, b, 0, 2);
        noise = 0;
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        int n;
        for (int t = 0; t < 6; t++) begin
            b.delete();
            n = $urandom_range(8, 1);
            repeat (4*n) b.push_back(8'($urandom));
            run_prog("random", n, b, 0, 4);
        end
    endtask

    task automatic test_full();
        logic [7:0] b[$];
        for (int i = 0; i < 512; i++) b.push_back(8'(i));
        run_prog("full128", 128, b, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_err();
        test_reset_mid();
        test_go_ignored();
        test_random();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
